// File: rtl/mdu_ctrl.sv
// Sequencer between EX and the mdu: one M-extension request at a time, local
// resolution of divide corner cases, and a held result under wb_valid/wb_ready.
module mdu_ctrl #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        mdu_valid,
  output logic [2:0]  mdu_op,
  output logic [31:0] mdu_rs1,
  output logic [31:0] mdu_rs2,
  input  logic [31:0] mdu_result,
  input  logic        mdu_ready,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err,
  output logic        busy
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        hit;
    logic        err;
    logic [31:0] data;
  } local_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       accept;
  logic       cnt_hit;
  local_t     loc;

  function automatic logic [2:0] map_op(input logic [2:0] f3);
    case (f3)
      3'b000:  map_op = 3'b000;
      3'b001:  map_op = 3'b001;
      3'b100:  map_op = 3'b010;
      3'b101:  map_op = 3'b011;
      3'b110:  map_op = 3'b100;
      3'b111:  map_op = 3'b101;
      default: map_op = 3'b000;
    endcase
  endfunction

  // Divide-by-zero, signed overflow and unsupported MULHSU/MULHU never reach the mdu.
  function automatic local_t resolve_local(input logic [2:0]         f3,
                                           input logic signed [31:0] a,
                                           input logic signed [31:0] b);
    logic ovf;
    logic zero;
    ovf  = (a == 32'sh8000_0000) && (b == -32'sd1);
    zero = (b == 32'sd0);
    resolve_local = '0;
    case (f3)
      3'b010, 3'b011: begin
        resolve_local.hit = 1'b1;
        resolve_local.err = 1'b1;
      end
      3'b100: begin
        resolve_local.hit  = zero | ovf;
        resolve_local.data = zero ? 32'hFFFF_FFFF : 32'h8000_0000;
      end
      3'b101: begin
        resolve_local.hit  = zero;
        resolve_local.data = 32'hFFFF_FFFF;
      end
      3'b110: begin
        resolve_local.hit  = zero | ovf;
        resolve_local.data = zero ? a : 32'd0;
      end
      3'b111: begin
        resolve_local.hit  = zero;
        resolve_local.data = a;
      end
      default: resolve_local = '0;
    endcase
  endfunction

  assign loc       = resolve_local(req_funct3, req_rs1, req_rs2);
  assign req_ready = ~rst & (state == IDLE) & ~flush;
  assign accept    = req_valid & req_ready;
  assign cnt_hit   = (cnt == LAT);
  assign mdu_valid = (state == ISSUE);
  assign wb_valid  = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = loc.hit ? RESP : ISSUE;
      ISSUE: state_nxt = flush ? IDLE : WAIT;
      WAIT: begin
        if (flush)                      state_nxt = IDLE;
        else if (cnt_hit && mdu_ready)  state_nxt = RESP;
      end
      RESP:  if (flush || wb_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, latency count and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdu_op  <= '0;
      mdu_rs1 <= '0;
      mdu_rs2 <= '0;
      wb_rd   <= '0;
      wb_data <= '0;
      wb_err  <= 1'b0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        mdu_op  <= map_op(req_funct3);
        mdu_rs1 <= req_rs1;
        mdu_rs2 <= req_rs2;
        wb_rd   <= req_rd;
        wb_data <= loc.data;
        wb_err  <= loc.err;
      end
      if (state == ISSUE) begin
        cnt <= 4'd1;
      end else if (state == WAIT && !cnt_hit) begin
        cnt <= cnt + 4'd1;
      end
      if (state == WAIT && !flush && cnt_hit && mdu_ready) begin
        wb_data <= mdu_result;
      end
      if (state == RESP && (flush || wb_ready)) begin
        wb_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: vector table for single requests plus
// hand-written sequences for flush, stalls and reset.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;
  logic        flush;
  logic        mdu_valid;
  logic [2:0]  mdu_op;
  logic [31:0] mdu_rs1;
  logic [31:0] mdu_rs2;
  logic [31:0] mdu_result;
  logic        mdu_ready;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  mdu_ctrl #(.LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .flush(flush),
    .mdu_valid(mdu_valid), .mdu_op(mdu_op), .mdu_rs1(mdu_rs1), .mdu_rs2(mdu_rs2),
    .mdu_result(mdu_result), .mdu_ready(mdu_ready),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_err(wb_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        loc;
    logic [2:0]  op;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic present(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_rs1    = a;
    req_rs2    = b;
    req_rd     = rd;
  endtask

  task automatic run_vec(input vec_t v);
    present(v.f3, v.rs1, v.rs2, v.rd);
    wb_ready   = 1'b1;
    mdu_ready  = 1'b1;
    mdu_result = 32'hDEAD_BEEF;
    #1;
    chk("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    if (v.loc) begin
      chk("loc_mdu_valid", mdu_valid, 0);
      chk("loc_wb_valid", wb_valid, 1);
      chk("loc_wb_data", wb_data, v.data);
      chk("loc_wb_err", wb_err, v.err);
      chk("loc_wb_rd", wb_rd, v.rd);
      next_cycle();
      chk("loc_wb_valid_off", wb_valid, 0);
      chk("loc_wb_err_clr", wb_err, 0);
      chk("loc_busy_off", busy, 0);
    end else begin
      chk("mdu_valid_c1", mdu_valid, 1);
      chk("mdu_op", mdu_op, v.op);
      chk("mdu_rs1", mdu_rs1, v.rs1);
      chk("mdu_rs2", mdu_rs2, v.rs2);
      chk("wb_valid_c1", wb_valid, 0);
      @(posedge clk); #1;
      mdu_result = v.data;
      #1;
      chk("mdu_valid_c2", mdu_valid, 0);
      chk("wb_valid_c2", wb_valid, 0);
      @(posedge clk); #1;
      mdu_result = 32'hDEAD_BEEF;
      #1;
      chk("wb_valid_c3", wb_valid, 1);
      chk("wb_data", wb_data, v.data);
      chk("wb_rd", wb_rd, v.rd);
      chk("wb_err", wb_err, 0);
      next_cycle();
      chk("wb_valid_c4", wb_valid, 0);
      chk("busy_c4", busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{3'b000, 32'd7,          32'd6,          5'd5,  1'b0, 3'b000, 32'd42,         1'b0};
    vecs[1]  = '{3'b100, 32'd10,         32'd0,          5'd6,  1'b1, 3'b000, 32'hFFFF_FFFF,  1'b0};
    vecs[2]  = '{3'b111, 32'd10,         32'd0,          5'd7,  1'b1, 3'b000, 32'd10,         1'b0};
    vecs[3]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  1'b1, 3'b000, 32'h8000_0000,  1'b0};
    vecs[4]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  1'b1, 3'b000, 32'd0,          1'b0};
    vecs[5]  = '{3'b011, 32'd3,          32'd4,          5'd10, 1'b1, 3'b000, 32'd0,          1'b1};
    vecs[6]  = '{3'b001, 32'hFFFF_FFFF,  32'd2,          5'd11, 1'b0, 3'b001, 32'hFFFF_FFFF,  1'b0};
    vecs[7]  = '{3'b111, 32'd17,         32'd5,          5'd12, 1'b0, 3'b101, 32'd2,          1'b0};
    vecs[8]  = '{3'b101, 32'd100,        32'd7,          5'd13, 1'b0, 3'b011, 32'd14,         1'b0};
    vecs[9]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          5'd14, 1'b0, 3'b100, 32'hFFFF_FFFF,  1'b0};
    vecs[10] = '{3'b100, 32'd20,         32'd4,          5'd15, 1'b0, 3'b010, 32'd5,          1'b0};
    vecs[11] = '{3'b010, 32'd1,          32'd1,          5'd16, 1'b1, 3'b000, 32'd0,          1'b1};
    vecs[12] = '{3'b101, 32'h1234_5678,  32'd0,          5'd17, 1'b1, 3'b000, 32'hFFFF_FFFF,  1'b0};
    vecs[13] = '{3'b110, 32'hFFFF_FF00,  32'd0,          5'd18, 1'b1, 3'b000, 32'hFFFF_FF00,  1'b0};

    rst = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_rs1 = '0; req_rs2 = '0;
    req_rd = '0; flush = 1'b0; mdu_result = '0; mdu_ready = 1'b1; wb_ready = 1'b0;
    #12;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mdu_valid", mdu_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wb_data", wb_data, 0);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    chk("post_rst_req_ready", req_ready, 1);

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Flush in WAIT, then a normal REMU must still work.
    present(3'b000, 32'd3, 32'd3, 5'd20);
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    flush = 1'b1; mdu_result = 32'd9;
    #1;
    chk("flush_wait_req_ready", req_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; mdu_result = 32'hDEAD_BEEF;
    #1;
    chk("flush_wait_busy", busy, 0);
    chk("flush_wait_wb_valid", wb_valid, 0);
    next_cycle();
    chk("flush_wait_wb_valid2", wb_valid, 0);
    run_vec(vecs[7]);

    // Flush in ISSUE: strobe still seen, result discarded.
    present(3'b001, 32'd5, 32'd5, 5'd21);
    next_cycle();
    req_valid = 1'b0; flush = 1'b1;
    #1;
    chk("flush_issue_mdu_valid", mdu_valid, 1);
    @(posedge clk); #1;
    flush = 1'b0; mdu_result = 32'd25;
    #1;
    chk("flush_issue_busy", busy, 0);
    next_cycle();
    chk("flush_issue_wb_valid", wb_valid, 0);

    // Writeback stall: result held, no new request accepted.
    wb_ready = 1'b0;
    present(3'b100, 32'd10, 32'd0, 5'd3);
    next_cycle();
    present(3'b000, 32'd1, 32'd1, 5'd4);
    for (int k = 0; k < 5; k++) begin
      chk("stall_wb_valid", wb_valid, 1);
      chk("stall_wb_data", wb_data, 32'hFFFF_FFFF);
      chk("stall_req_ready", req_ready, 0);
      next_cycle();
    end
    wb_ready = 1'b1;
    #1;
    chk("stall_release_req_ready", req_ready, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    chk("stall_release_wb_valid", wb_valid, 0);
    chk("stall_release_req_ready2", req_ready, 1);

    // mdu_ready low at the latency point: capture waits for it.
    present(3'b000, 32'd8, 32'd8, 5'd22);
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    mdu_ready = 1'b0; mdu_result = 32'hDEAD_BEEF;
    next_cycle();
    chk("mready_hold_wb_valid", wb_valid, 0);
    next_cycle();
    chk("mready_hold_busy", busy, 1);
    mdu_ready = 1'b1; mdu_result = 32'd64;
    next_cycle();
    mdu_result = 32'hDEAD_BEEF;
    chk("mready_wb_valid", wb_valid, 1);
    chk("mready_wb_data", wb_data, 32'd64);
    next_cycle();

    // Flush beats wb_ready in RESP and clears wb_err.
    present(3'b011, 32'd1, 32'd2, 5'd23);
    next_cycle();
    req_valid = 1'b0; flush = 1'b1;
    #1;
    chk("flush_resp_err", wb_err, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("flush_resp_wb_valid", wb_valid, 0);
    chk("flush_resp_err_clr", wb_err, 0);

    // Reset mid-WAIT clears everything at once.
    present(3'b001, 32'hFFFF_FFFF, 32'd2, 5'd24);
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_mdu_op", mdu_op, 0);
    chk("rst_mid_mdu_rs1", mdu_rs1, 0);
    chk("rst_mid_mdu_rs2", mdu_rs2, 0);
    chk("rst_mid_wb_rd", wb_rd, 0);
    chk("rst_mid_wb_valid", wb_valid, 0);
    chk("rst_mid_req_ready", req_ready, 0);
    chk("rst_mid_mdu_valid", mdu_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    chk("rst_mid_release_req_ready", req_ready, 1);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
